g711_compress: RTL and testbench

- Sequential G.711 compressor: converts a 14-bit two's-complement linear sample to an 8-bit A-law or u-law PCM code.
- Inverse of the existing G711 expander; sits on the decoder output path ahead of the PCM line interface.
- Segment search is iterative, one threshold compare per clock.
- Valid/ready handshakes on both input and output.

---
 rtl/g711_compress.sv | 139 +++++++++++++
 tb/tb_g711_compress.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/g711_compress.sv
// Iterative G.711 compressor: 14-bit linear sample to 8-bit A-law/u-law code, one segment compare per clock.
// Optional macro G711_CLIP_FLAG_EN adds clip_out, flagging samples that saturated the magnitude.
module g711_compress #(
    parameter int LIN_W     = 14,
    parameter int ULAW_BIAS = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             law,
    input  logic [LIN_W-1:0] lin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       pcm_out,
`ifdef G711_CLIP_FLAG_EN
    output logic             clip_out,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state_q, state_d;
    logic        law_q, law_d;
    logic        neg_q, neg_d;
    logic [12:0] mag_q, mag_d;
    logic [2:0]  s_q, s_d;
    logic [7:0]  pcm_q, pcm_d;

    // One's complement of a negative sample folds it onto 0..8191
    logic [12:0] in_abs;
    logic [14:0] absno_raw;
    logic [12:0] ulaw_mag;
    logic [12:0] alaw_mag;
    logic [13:0] thr;
    logic        hit;
    logic [3:0]  ush, ash;
    logic [3:0]  umant, amant;
    logic [7:0]  code;

    always_comb begin
        in_abs    = lin_in[LIN_W-1] ? ~lin_in[LIN_W-2:0] : lin_in[LIN_W-2:0];
        absno_raw = {2'b00, in_abs} + 15'(ULAW_BIAS);
        ulaw_mag  = (absno_raw > 15'd8191) ? 13'h1FFF : absno_raw[12:0];
        alaw_mag  = {2'b00, in_abs[12:2]};

        thr = law_q ? (14'd16 << s_q) : (14'd64 << s_q);
        hit = ({1'b0, mag_q} < thr) || (s_q == 3'd7);

        ush   = {1'b0, s_q} + 4'd1;
        ash   = (s_q == 3'd0) ? 4'd0 : ({1'b0, s_q} - 4'd1);
        umant = 4'(mag_q >> ush);
        amant = 4'(mag_q >> ash);
        code  = law_q ? ({~neg_q, s_q, amant} ^ 8'h55) : {~neg_q, ~s_q, ~umant};
    end

`ifdef G711_CLIP_FLAG_EN
    logic clip_pend_q, clip_pend_d;
    logic clip_q, clip_d;
    logic clip_raw;
    assign clip_raw = law ? (in_abs[12:2] == 11'h7FF) : (absno_raw > 15'd8191);
`endif

    always_comb begin
        state_d = state_q;
        law_d   = law_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        s_d     = s_q;
        pcm_d   = pcm_q;
`ifdef G711_CLIP_FLAG_EN
        clip_pend_d = clip_pend_q;
        clip_d      = clip_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    law_d   = law;
                    neg_d   = lin_in[LIN_W-1];
                    mag_d   = law ? alaw_mag : ulaw_mag;
                    s_d     = 3'd0;
                    state_d = SEARCH;
`ifdef G711_CLIP_FLAG_EN
                    clip_pend_d = clip_raw;
`endif
                end
            end
            SEARCH: begin
                if (hit) begin
                    pcm_d   = code;
                    state_d = DONE;
`ifdef G711_CLIP_FLAG_EN
                    clip_d = clip_pend_q;
`endif
                end else begin
                    s_d = s_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            law_q   <= 1'b0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            s_q     <= '0;
            pcm_q   <= 8'h00;
`ifdef G711_CLIP_FLAG_EN
            clip_pend_q <= 1'b0;
            clip_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            law_q   <= law_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            s_q     <= s_d;
            pcm_q   <= pcm_d;
`ifdef G711_CLIP_FLAG_EN
            clip_pend_q <= clip_pend_d;
            clip_q      <= clip_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign pcm_out   = pcm_q;
`ifdef G711_CLIP_FLAG_EN
    assign clip_out  = clip_q;
`endif

endmodule

// File: tb/tb_g711_compress.sv
// Scoreboard bench for g711_compress: arithmetic reference model, decoupled monitor, directed + random stimulus.
module tb_g711_compress;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        law = 1'b0;
    logic [13:0] lin_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  pcm_out;
    logic        out_valid;
    logic        out_ready;
`ifdef G711_CLIP_FLAG_EN
    logic        clip_out;
`endif

    logic rdy_mode = 1'b0;  // 0: manual, 1: random
    logic rdy_man  = 1'b1;
    logic rdy_rnd  = 1'b1;
    assign out_ready = rdy_mode ? rdy_rnd : rdy_man;

    g711_compress dut (
        .clk(clk), .reset(reset), .law(law), .lin_in(lin_in),
        .in_valid(in_valid), .in_ready(in_ready), .pcm_out(pcm_out),
`ifdef G711_CLIP_FLAG_EN
        .clip_out(clip_out),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pcm;
        logic       clip;
        int         seg;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic int nbits(input int v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int clamp7(input int v);
        return (v < 0) ? 0 : ((v > 7) ? 7 : v);
    endfunction

    // Reference: G.711 rules in plain integer arithmetic
    function automatic exp_t model(input logic l, input logic [13:0] x);
        exp_t e;
        int xi, m, raw, absno, ix, mant, neg;
        xi  = int'($signed(x));
        neg = (xi < 0) ? 1 : 0;
        m   = neg ? (-xi - 1) : xi;
        if (!l) begin
            raw   = m + 33;
            absno = (raw > 8191) ? 8191 : raw;
            e.seg = clamp7(nbits(absno) - 6);
            mant  = (absno >> (e.seg + 1)) % 16;
            e.pcm = 8'((neg ? 0 : 128) + (7 - e.seg) * 16 + (15 - mant));
            e.clip = (raw > 8191);
        end else begin
            ix    = m / 4;
            e.seg = clamp7(nbits(ix) - 4);
            mant  = (e.seg == 0) ? (ix % 16) : ((ix >> (e.seg - 1)) % 16);
            e.pcm = 8'(((neg ? 0 : 128) + e.seg * 16 + mant) ^ 'h55);
            e.clip = (ix == 2047);
        end
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) rdy_rnd <= 1'($urandom_range(0, 1));

    // Accept recorder: expected result is queued at the handshake edge
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!reset && in_valid && in_ready) begin
            e = model(law, lin_in);
            e.acc = cyc;
            sb.push_back(e);
            n_acc++;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pcm 0x%0h with no sample pending", pcm_out);
                end else begin
                    if (!prev_v) chk("latency", cyc - sb[0].acc, sb[0].seg + 1);
                    chk("pcm_out", int'(pcm_out), int'(sb[0].pcm));
`ifdef G711_CLIP_FLAG_EN
                    chk("clip_out", int'(clip_out), int'(sb[0].clip));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic send(input logic l, input logic [13:0] x);
        int n0;
        bit got;
        n0 = n_acc;
        got = 0;
        @(negedge clk);
        law = l;
        lin_in = x;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (n_acc != n0) got = 1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) chk("valid_timeout", 0, 1);
    endtask

    logic [13:0] dir_lin [12] = '{14'h0000, 14'h3FFF, 14'd100, 14'h1FFF, 14'h2000,
                                  14'd8158, 14'd8159, 14'h2021, 14'h2022, 14'd31,
                                  14'd63, 14'h3F00};

    initial begin
        bit seen;
        int n0;
        bit drained;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_pcm_out", int'(pcm_out), 0);

        // Directed: both laws over zero, -1, mid, extremes and saturation edges
        rdy_man = 1'b1;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 12; i++) send(1'(l), dir_lin[i]);
        repeat (12) @(posedge clk);

        // Backpressure: hold result, second sample must wait
        rdy_man = 1'b0;
        send(1'b0, 14'd100);
        @(negedge clk);
        law = 1'b1;
        lin_in = 14'h1FFF;
        in_valid = 1'b1;
        wait_valid(seen);
        n0 = n_acc;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_no_accept", n_acc, n0);
        end
        @(negedge clk);
        rdy_man = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_second_accept", n_acc, n0 + 1);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Reset during SEARCH discards the sample
        send(1'b0, 14'h1FFF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_pcm_out", int'(pcm_out), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        sb.delete();
        repeat (12) @(posedge clk);

        // Random samples with random backpressure
        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) send(1'($urandom_range(0, 1)), 14'($urandom));

        drained = 0;
        for (int i = 0; i < 200 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0) drained = 1;
        end
        if (!drained) chk("drain_timeout", sb.size(), 0);
        chk("total_accepts", n_acc, 24 + 2 + 1 + 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
